inst_sram_resp: RTL
===================

Name: inst_sram_resp

Overview:
- Responder (slave) end of the instruction-SRAM interface driven by the fetch stage.
- Synchronous single-port word memory: en/we/addr/wdata sampled at posedge clk, rdata returned exactly one cycle later.
- Supports byte-lane writes, a bench/boot preload port, an out-of-range error flag and saturating access counters.
- Used as the instruction memory in simulation and FPGA top levels.

Parameters:
ADDR_BASE, 32'h1c000000, byte address of word 0 (first fetch address after reset).
DEPTH_LOG2, 12, log2 of the number of 32-bit words (default 4096 words = 16 KiB).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
sram_en  in  1  access request this cycle
sram_we  in  4  byte write enables; 4'b0000 = read
sram_addr  in  32  byte address; bits [1:0] ignored
sram_wdata  in  32  write data; byte i uses bits [8i+7:8i]
sram_rdata  out  32  read data, registered
load_en  in  1  preload write strobe
load_idx  in  DEPTH_LOG2  preload word index
load_data  in  32  preload word
err_oob  out  1  sticky: an out-of-range access occurred
rd_cnt  out  32  accepted read count, saturating
wr_cnt  out  32  accepted write count, saturating

Behaviour:
- Address decode:
  - off = sram_addr - ADDR_BASE, 32-bit unsigned subtraction.
  - in_range = (off >> 2) < 2^DEPTH_LOG2; addresses below ADDR_BASE wrap to large values, so they are out of range.
  - idx = off[DEPTH_LOG2+1:2].
- Reset cycle: sram_rdata <= 0, err_oob <= 0, rd_cnt <= 0, wr_cnt <= 0. Port access and preload are both ignored. Memory contents are NOT cleared.
- Read (en=1, we=0, in_range): sram_rdata <= mem[idx] at this edge, so the data is visible in the next cycle (latency 1). rd_cnt +1.
- Write (en=1, we!=0, in_range):
  - For each lane i with we[i]=1: mem[idx] byte i <= wdata byte i. Other bytes are unchanged.
  - Read-first: sram_rdata <= mem[idx] value before the write.
  - wr_cnt +1.
- Out of range (en=1, !in_range): no memory change; sram_rdata <= 0; err_oob <= 1; the access is not counted.
- Idle (en=0): sram_rdata holds its previous value. No counter change.
- Back-to-back accesses every cycle are supported; there is no stall and no ready signal.
- Preload (load_en=1, not reset): mem[load_idx] <= load_data, full word.
  - Does not affect sram_rdata, the counters or err_oob.
- Port write and preload to the same index in the same cycle: preload wins for all bytes. A same-cycle port read of that index returns the pre-edge value.
- Counters saturate at 32'hffffffff. err_oob clears only on reset.
- Read of a never-written word: X in simulation. The bench must preload before reading.

Decomposition:
- Shared package: INST_BASE (32'h1c000000), the reset-PC constant (32'h1bfffffc), and the SRAM interface widths (address 32, data 32, write-enable 4).
- One natural sub-module: sat_cnt32 (increment-enable 32-bit saturating counter), instantiated twice.
- The memory array stays inline so synthesis infers block RAM.

Test Plan:
- Preload idx 0 = 32'h02800c0c; reset; en=1, addr=32'h1c000000, we=0 -> next cycle rdata=32'h02800c0c, rd_cnt=1.
- Preload idx 1 = 32'h11223344; write addr=32'h1c000004, we=4'b0101, wdata=32'haabbccdd -> that cycle's returned rdata=32'h11223344 (read-first); a following read returns 32'h11bb33dd, wr_cnt=1.
- Reads of 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles, then en=0 for 3 cycles -> rdata follows each address one cycle later, then holds the last word; rd_cnt=3.
- Read addr=32'h1bfffffc and then addr=32'h1c004000 -> rdata=0 each time, err_oob=1 and stays 1, rd_cnt unchanged; the next reset clears err_oob.
- Same cycle: port write idx 2 (we=4'hf, wdata=32'h1) and load_en idx 2 load_data=32'h2 -> a subsequent read returns 32'h2, wr_cnt=1.
- Reset asserted with en=1, we=4'hf, addr=0x1c000000 -> mem[0] unchanged after reset; rdata=0.

Source files
------------

// File: rtl/inst_sram_resp_pkg.sv
// Shared constants for the instruction-SRAM responder: fetch base address,
// reset PC and the SRAM interface widths.
package inst_sram_resp_pkg;

   localparam logic [31:0] INST_BASE = 32'h1c000000;
   localparam logic [31:0] RESET_PC  = 32'h1bfffffc;

   localparam int unsigned SRAM_AW  = 32;
   localparam int unsigned SRAM_DW  = 32;
   localparam int unsigned SRAM_WEW = 4;

endpackage : inst_sram_resp_pkg

// File: rtl/inst_sram_resp_sat_cnt32.sv
// 32-bit up-counter with increment enable that sticks at all-ones.
module sat_cnt32 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 32'hffffffff)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_cnt32

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: single-port word memory with byte-lane writes,
// preload port, sticky out-of-range flag and saturating access counters.
module inst_sram_resp
   import inst_sram_resp_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE  = INST_BASE,
   parameter int unsigned DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sram_en,
   input  logic [SRAM_WEW-1:0]   sram_we,
   input  logic [SRAM_AW-1:0]    sram_addr,
   input  logic [SRAM_DW-1:0]    sram_wdata,
   output logic [SRAM_DW-1:0]    sram_rdata,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_idx,
   input  logic [SRAM_DW-1:0]    load_data,
   output logic                  err_oob,
   output logic [31:0]           rd_cnt,
   output logic [31:0]           wr_cnt
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   // Handshake: sram_en is a request that is always accepted at the edge it is
   // sampled; there is no ready/stall, and the response appears one cycle later.

   logic [SRAM_DW-1:0]    mem [DEPTH];

   logic [31:0]           off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  is_write;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  unused_addr_lsb;

   logic [SRAM_DW-1:0]    rdata_q;
   logic [SRAM_DW-1:0]    rdata_d;
   logic                  err_q;
   logic                  err_d;

   // Addresses below the base wrap to huge offsets and fail the range test.
   assign off             = sram_addr - ADDR_BASE;
   assign in_range        = (off[31:DEPTH_LOG2+2] == '0);
   assign idx             = off[DEPTH_LOG2+1:2];
   assign unused_addr_lsb = ^off[1:0];

   assign is_write = (sram_we != '0);
   assign rd_acc   = !reset && sram_en && in_range && !is_write;
   assign wr_acc   = !reset && sram_en && in_range &&  is_write;

   // Preload is written last so it overrides every lane of a same-index port write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr_acc) begin
            for (int i = 0; i < SRAM_WEW; i++) begin
               if (sram_we[i]) begin
                  mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
               end
            end
         end
         if (load_en) begin
            mem[load_idx] <= load_data;
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (sram_en) begin
         if (in_range) begin
            rdata_d = mem[idx];
         end else begin
            rdata_d = '0;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign sram_rdata = rdata_q;
   assign err_oob    = err_q;

   sat_cnt32 u_rd_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (rd_acc),
      .cnt_o (rd_cnt)
   );

   sat_cnt32 u_wr_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (wr_acc),
      .cnt_o (wr_cnt)
   );

endmodule : inst_sram_resp
